huffman_encoder: RTL and testbench

//  Serialises 3-bit symbols into the fixed prefix-free Huffman bitstream consumed by huffman_decoder.

---
 rtl/huffman_encoder_pkg.sv | 57 +++++
 rtl/huffman_encoder_if.sv | 24 ++
 rtl/huffman_encoder_code_rom.sv | 18 +
 rtl/huffman_encoder.sv | 80 ++++++++
 tb/tb_huffman_encoder.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/huffman_encoder_pkg.sv
// Shared constants, codebook and symbol type for the Huffman encoder/decoder pair.
// The codebook lives here so the encoder ROM and decoder reference model share one source of truth.
package huff_pkg;

  localparam int SYM_W        = 3;
  localparam int CODE_MAX_LEN = 4;
  localparam int CNT_W        = 3;

  localparam logic                IDLE_BIT = 1'b0;
  localparam logic [CNT_W-1:0]    CNT_ONE  = 3'd1;

  typedef enum logic [SYM_W-1:0] {
    SYM_1 = 3'd1,
    SYM_2 = 3'd2,
    SYM_3 = 3'd3,
    SYM_4 = 3'd4,
    SYM_5 = 3'd5,
    SYM_6 = 3'd6
  } sym_e;

  // Codewords are left-aligned in CODE_MAX_LEN bits; unused low bits are zero.
  localparam logic [CODE_MAX_LEN-1:0] CODE_1 = 4'b0000;
  localparam logic [CODE_MAX_LEN-1:0] CODE_2 = 4'b1010;
  localparam logic [CODE_MAX_LEN-1:0] CODE_3 = 4'b1000;
  localparam logic [CODE_MAX_LEN-1:0] CODE_4 = 4'b1110;
  localparam logic [CODE_MAX_LEN-1:0] CODE_5 = 4'b1101;
  localparam logic [CODE_MAX_LEN-1:0] CODE_6 = 4'b1100;

  localparam logic [CNT_W-1:0] LEN_1 = 3'd1;
  localparam logic [CNT_W-1:0] LEN_2 = 3'd3;
  localparam logic [CNT_W-1:0] LEN_3 = 3'd3;
  localparam logic [CNT_W-1:0] LEN_4 = 3'd3;
  localparam logic [CNT_W-1:0] LEN_5 = 3'd4;
  localparam logic [CNT_W-1:0] LEN_6 = 3'd4;

  typedef struct packed {
    logic [CODE_MAX_LEN-1:0] code;
    logic [CNT_W-1:0]        len;
    logic                    illegal;
  } code_entry_t;

  function automatic code_entry_t lookup_code(input logic [SYM_W-1:0] sym);
    code_entry_t entry;
    entry = '{code: '0, len: '0, illegal: 1'b1};
    case (sym)
      SYM_1:   entry = '{code: CODE_1, len: LEN_1, illegal: 1'b0};
      SYM_2:   entry = '{code: CODE_2, len: LEN_2, illegal: 1'b0};
      SYM_3:   entry = '{code: CODE_3, len: LEN_3, illegal: 1'b0};
      SYM_4:   entry = '{code: CODE_4, len: LEN_4, illegal: 1'b0};
      SYM_5:   entry = '{code: CODE_5, len: LEN_5, illegal: 1'b0};
      SYM_6:   entry = '{code: CODE_6, len: LEN_6, illegal: 1'b0};
      default: entry = '{code: '0, len: '0, illegal: 1'b1};
    endcase
    return entry;
  endfunction

endpackage

// File: rtl/huffman_encoder_if.sv
// Symbol handshake plus serial bitstream bundle between symbol source, encoder and decoder.
interface huffman_encoder_if;
  import huff_pkg::*;

  logic [SYM_W-1:0] sym;
  logic             sym_valid;
  logic             sym_ready;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             err;

  // master = symbol source / stream observer, slave = encoder
  modport master (
    output sym, sym_valid,
    input  sym_ready, x, x_valid, busy, err
  );

  modport slave (
    input  sym, sym_valid,
    output sym_ready, x, x_valid, busy, err
  );

endinterface

// File: rtl/huffman_encoder_code_rom.sv
// Combinational codebook lookup: symbol -> left-aligned codeword, length and illegal flag.
module huffman_code_rom
  import huff_pkg::*;
(
  input  logic [SYM_W-1:0]        i_sym,
  output logic [CODE_MAX_LEN-1:0] o_code,
  output logic [CNT_W-1:0]        o_len,
  output logic                    o_illegal
);

  code_entry_t w_entry;

  assign w_entry   = lookup_code(i_sym);
  assign o_code    = w_entry.code;
  assign o_len     = w_entry.len;
  assign o_illegal = w_entry.illegal;

endmodule

// File: rtl/huffman_encoder.sv
// Serialises 3-bit symbols into a prefix-free Huffman bitstream, MSB first, one bit per clock.
// A new symbol is accepted while idle or while the last bit of the current codeword is on x.
module huffman_encoder
  import huff_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  huffman_encoder_if.slave bus
);

  logic [CODE_MAX_LEN-1:0] r_sh;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_err;

  logic [CODE_MAX_LEN-1:0] w_sh_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_err_nxt;

  logic [CODE_MAX_LEN-1:0] w_rom_code;
  logic [CNT_W-1:0]        w_rom_len;
  logic                    w_rom_illegal;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_active;

  huffman_code_rom u_code_rom (
    .i_sym     (bus.sym),
    .o_code    (w_rom_code),
    .o_len     (w_rom_len),
    .o_illegal (w_rom_illegal)
  );

  // Ready depends on registered state only, so it never combinationally follows sym_valid.
  assign w_ready  = (r_cnt <= CNT_ONE);
  assign w_accept = bus.sym_valid & w_ready;
  assign w_active = (r_cnt != '0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_sh_nxt  = r_sh;
    w_cnt_nxt = r_cnt;
    w_err_nxt = 1'b0;

    if (w_accept && !w_rom_illegal) begin
      w_sh_nxt  = w_rom_code;
      w_cnt_nxt = w_rom_len;
    end else if (r_cnt > CNT_ONE) begin
      w_sh_nxt  = {r_sh[CODE_MAX_LEN-2:0], 1'b0};
      w_cnt_nxt = r_cnt - CNT_ONE;
    end else begin
      // Last bit (if any) leaves x this edge; an illegal symbol adds nothing behind it.
      w_sh_nxt  = '0;
      w_cnt_nxt = '0;
    end

    if (w_accept && w_rom_illegal) begin
      w_err_nxt = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh  <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_sh  <= w_sh_nxt;
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign bus.sym_ready = w_ready;
  assign bus.x_valid   = w_active;
  assign bus.x         = w_active ? r_sh[CODE_MAX_LEN-1] : IDLE_BIT;
  assign bus.busy      = w_active;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_huffman_encoder.sv
// Randomised scoreboard bench for huffman_encoder with a behavioural bit-queue model and prefix decoder.
module tb_huffman_encoder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  huffman_encoder_if bus ();

  huffman_encoder u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  bit exp_q[$];
  int sent_q[$];
  bit exp_err = 1'b0;
  int dec_code = 0;
  int dec_len  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference codebook as plain integers; len 0 marks an illegal symbol.
  function automatic void ref_code(input int s, output int code, output int len);
    case (s)
      1:       begin code = 0;  len = 1; end
      2:       begin code = 5;  len = 3; end
      3:       begin code = 4;  len = 3; end
      4:       begin code = 7;  len = 3; end
      5:       begin code = 13; len = 4; end
      6:       begin code = 12; len = 4; end
      default: begin code = 0;  len = 0; end
    endcase
  endfunction

  // One clock of stimulus: present inputs, predict acceptance, enqueue expected bits at the edge.
  task automatic drive_cycle(input bit valid, input int s, output bit acc);
    int code;
    int len;
    code = 0;
    len  = 0;
    bus.sym_valid = valid;
    bus.sym       = s[2:0];
    acc = valid && (bus.sym_ready === 1'b1);
    @(posedge clk);
    if (acc) begin
      ref_code(s, code, len);
      for (int i = len - 1; i >= 0; i--) exp_q.push_back(code[i]);
      if (len != 0) sent_q.push_back(s);
    end
    exp_err = acc && (len == 0);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 0, acc);
  endtask

  task automatic send(input int s);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      drive_cycle(1'b1, s, acc);
      tries++;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic flush_model();
    exp_q.delete();
    sent_q.delete();
    exp_err  = 1'b0;
    dec_code = 0;
    dec_len  = 0;
  endtask

  // Monitor: the model says a bit is on x exactly when the expected-bit queue is non-empty.
  always @(negedge clk) begin
    int  code;
    int  len;
    int  hit;
    bit  b;
    check("x_valid",   bus.x_valid,   32'(exp_q.size() != 0));
    check("busy",      bus.busy,      32'(exp_q.size() != 0));
    check("sym_ready", bus.sym_ready, 32'(exp_q.size() <= 1));
    check("err",       bus.err,       32'(exp_err));
    if (exp_q.size() != 0) begin
      b = exp_q.pop_front();
      check("x", bus.x, 32'(b));
    end else begin
      check("x_idle", bus.x, 0);
    end
    if (bus.x_valid === 1'b1) begin
      dec_code = dec_code * 2 + ((bus.x === 1'b1) ? 1 : 0);
      dec_len++;
      hit = 0;
      for (int s = 1; s <= 6; s++) begin
        ref_code(s, code, len);
        if (len == dec_len && code == dec_code) hit = s;
      end
      if (hit != 0) begin
        if (sent_q.size() == 0) check("dec_extra_symbol", hit, 0);
        else check("decoded_symbol", hit, sent_q.pop_front());
        dec_code = 0;
        dec_len  = 0;
      end else if (dec_len >= 4) begin
        check("dec_bad_prefix", dec_code, 32'hFFFF_FFFF);
        dec_code = 0;
        dec_len  = 0;
      end
    end
  end

  initial begin
    bit acc;
    int n;
    int code;
    int len;
    int accepted;
    int cycles;
    bit pend;
    int cur;

    reset         = 1'b1;
    bus.sym_valid = 1'b0;
    bus.sym       = '0;
    flush_model();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // T1: single 1-bit codeword
    send(1);
    idle(3);

    // T2: back-to-back 5 then 2 stream 1101101 with no bubble
    send(5);
    send(2);
    idle(5);

    // T3: illegal symbols pulse err, emit nothing
    send(0);
    idle(1);
    send(7);
    idle(2);
    send(4);
    idle(4);

    // T4: asynchronous reset mid-codeword
    send(6);
    idle(1);
    #2;
    reset = 1'b1;
    flush_model();
    #1;
    check("reset_async_x_valid", bus.x_valid, 0);
    check("reset_async_busy", bus.busy, 0);
    check("reset_sym_ready", bus.sym_ready, 1);
    check("reset_x_idle", bus.x, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_after_reset", bus.sym_ready, 1);
    @(negedge clk);
    send(3);
    idle(4);

    // T5: held sym_valid is consumed exactly once, on the last-bit cycle
    send(5);
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      drive_cycle(1'b1, 4, acc);
      n++;
    end
    ref_code(5, code, len);
    check("t5_accept_cycle", n, len);
    idle(5);

    // T6: 1000 random legal symbols with random bubbles; decoded back by the monitor
    accepted = 0;
    cycles   = 0;
    pend     = 1'b0;
    cur      = 1;
    while (accepted < 1000 && cycles < 20000) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        cur  = $urandom_range(1, 6);
      end
      drive_cycle(pend, cur, acc);
      cycles++;
      if (acc) begin
        accepted++;
        pend = 1'b0;
      end
    end
    check("t6_accepted", accepted, 1000);
    idle(6);

    // Mixed legal/illegal random phase
    accepted = 0;
    cycles   = 0;
    pend     = 1'b0;
    while (accepted < 200 && cycles < 5000) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend = 1'b1;
        cur  = $urandom_range(0, 7);
      end
      drive_cycle(pend, cur, acc);
      cycles++;
      if (acc) begin
        accepted++;
        pend = 1'b0;
      end
    end
    check("mixed_accepted", accepted, 200);
    idle(6);

    check("exp_q_drained", exp_q.size(), 0);
    check("sent_q_drained", sent_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
